// File: rtl/spi_transaction_fsm_if.sv
// Control/handshake bundle between the SPI input conditioners, the
// transaction sequencer and the datapath strobes it drives.
interface spi_transaction_fsm_if;
  logic cs_n;
  logic sclk_posedge;
  logic rw_bit;
  logic sr_shift_en;
  logic sr_load;
  logic addr_we;
  logic dm_we;
  logic miso_en;

  modport master (
    output cs_n, sclk_posedge, rw_bit,
    input  sr_shift_en, sr_load, addr_we, dm_we, miso_en
  );

  modport slave (
    input  cs_n, sclk_posedge, rw_bit,
    output sr_shift_en, sr_load, addr_we, dm_we, miso_en
  );
endinterface

// File: rtl/spi_transaction_fsm.sv
// SPI memory transaction sequencer: address + R/W phase, then a read-out or
// write-in data phase, one transaction per chip-select assertion.
module spi_transaction_fsm #(
  parameter int ADDR_BITS = 7,
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 4
) (
  input logic                  clk,
  input logic                  reset,
  spi_transaction_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GOT_ADDR, READ_LOAD, READ_SHIFT, WRITE_GET, WRITE_DM, DONE
  } state_t;

  // Terminal counts: the address phase carries the extra R/W bit.
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BITS);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             addr_we_r, sr_load_r, dm_we_r, miso_en_r;

  // Strobes are registered against the state being entered, so each one is
  // high exactly while the FSM sits in the owning state.
  always_ff @(posedge clk) begin
    addr_we_r <= 1'b0;
    sr_load_r <= 1'b0;
    dm_we_r   <= 1'b0;
    miso_en_r <= 1'b0;
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state != IDLE && bus.cs_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!bus.cs_n) state <= GET_ADDR;
        end
        GET_ADDR: if (bus.sclk_posedge) begin
          if (cnt == ADDR_LAST) begin
            state     <= GOT_ADDR;
            cnt       <= '0;
            addr_we_r <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GOT_ADDR: begin
          cnt <= '0;
          if (bus.rw_bit) begin
            state     <= READ_LOAD;
            sr_load_r <= 1'b1;
          end else begin
            state <= WRITE_GET;
          end
        end
        READ_LOAD: begin
          state     <= READ_SHIFT;
          cnt       <= '0;
          miso_en_r <= 1'b1;
        end
        READ_SHIFT: begin
          miso_en_r <= 1'b1;
          if (bus.sclk_posedge) begin
            if (cnt == DATA_LAST) begin
              state     <= DONE;
              cnt       <= '0;
              miso_en_r <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        WRITE_GET: if (bus.sclk_posedge) begin
          if (cnt == DATA_LAST) begin
            state   <= WRITE_DM;
            cnt     <= '0;
            dm_we_r <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WRITE_DM: begin
          state <= DONE;
          cnt   <= '0;
        end
        DONE:    cnt <= '0;
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.sr_shift_en = bus.sclk_posedge & ~bus.cs_n &
                           (state inside {GET_ADDR, READ_SHIFT, WRITE_GET});
  assign bus.addr_we     = addr_we_r;
  assign bus.sr_load     = sr_load_r;
  assign bus.dm_we       = dm_we_r;
  assign bus.miso_en     = miso_en_r;

endmodule

// File: tb/tb_spi_transaction_fsm.sv
// Directed bench for spi_transaction_fsm: pulse-count model checked every
// cycle, plus literal timing expectations at key points of each transaction.
module tb_spi_transaction_fsm;
  localparam int A = 7;
  localparam int D = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  spi_transaction_fsm_if bus();

  spi_transaction_fsm #(.ADDR_BITS(A), .DATA_BITS(D), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int dm_cnt = 0;
  logic last_shift;

  // Model: a transaction is described by accepted address pulses (ap),
  // accepted data pulses (dp) and cycles elapsed since the address finished.
  bit mv = 0, busy = 0, rd = 0, fin = 0;
  int ap = 0, dp = 0, post = 0;

  function automatic bit m_window();
    return busy && ((post == 0 && ap <= A) ||
                    (post >= (rd ? 3 : 2) && dp < D && !fin));
  endfunction

  function automatic bit m_dm();
    return busy && !rd && post >= 2 && dp == D && !fin;
  endfunction

  always @(posedge clk) begin
    bit acc, dmc;
    if (reset) begin
      mv = 1; busy = 0; ap = 0; dp = 0; post = 0; rd = 0; fin = 0;
    end else if (!busy) begin
      if (!bus.cs_n) begin
        busy = 1; ap = 0; dp = 0; post = 0; rd = 0; fin = 0;
      end
    end else if (bus.cs_n) begin
      busy = 0; ap = 0; dp = 0; post = 0; rd = 0; fin = 0;
    end else begin
      acc = bus.sclk_posedge && m_window();
      dmc = m_dm();
      if (post == 1) rd = bus.rw_bit;
      if (dmc) fin = 1;
      if (post > 0 && post < 1000) post++;
      if (acc) begin
        if (post == 0) begin
          ap++;
          if (ap == A + 1) post = 1;
        end else begin
          dp++;
        end
      end
    end
  end

  task automatic chk(string nm, logic act, logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (mv && !reset) begin
      chk("m_shift", bus.sr_shift_en,
          busy && !bus.cs_n && bus.sclk_posedge && m_window());
      chk("m_addr_we", bus.addr_we, busy && post == 1);
      chk("m_sr_load", bus.sr_load, busy && rd && post == 2);
      chk("m_miso_en", bus.miso_en, busy && rd && post >= 3 && dp < D);
      chk("m_dm_we",   bus.dm_we,   m_dm());
    end
    if (bus.dm_we === 1'b1) dm_cnt++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse(int gap);
    bus.sclk_posedge = 1'b1;
    #1 last_shift = bus.sr_shift_en;
    tick();
    bus.sclk_posedge = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic outs_zero(string nm);
    chk({nm, "_shift"}, bus.sr_shift_en, 1'b0);
    chk({nm, "_addr"},  bus.addr_we,     1'b0);
    chk({nm, "_load"},  bus.sr_load,     1'b0);
    chk({nm, "_dm"},    bus.dm_we,       1'b0);
    chk({nm, "_miso"},  bus.miso_en,     1'b0);
  endtask

  // Address phase: cs_n already low for a cycle; ends in the addr_we cycle.
  task automatic addr_phase(logic rw);
    for (int i = 0; i < A + 1; i++) begin
      if (i == A) bus.rw_bit = rw;
      pulse(i == A ? 0 : 3);
      chk("addr_pulse_shift", last_shift, 1'b1);
      if (i < A) chk("addr_we_early", bus.addr_we, 1'b0);
    end
    chk("addr_we_lat", bus.addr_we, 1'b1);
  endtask

  initial begin
    bus.cs_n = 1'b1; bus.sclk_posedge = 1'b0; bus.rw_bit = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    outs_zero("reset");

    // Read transaction
    bus.cs_n = 1'b0; tick();
    addr_phase(1'b1);
    tick();
    chk("rd_sr_load", bus.sr_load, 1'b1);
    chk("rd_addr_we_off", bus.addr_we, 1'b0);
    tick();
    chk("rd_miso_on", bus.miso_en, 1'b1);
    for (int i = 0; i < D; i++) begin
      pulse(i == D - 1 ? 0 : 3);
      chk("rd_data_shift", last_shift, 1'b1);
    end
    chk("rd_miso_off", bus.miso_en, 1'b0);
    pulse(1);
    chk("done_no_shift", last_shift, 1'b0);
    bus.cs_n = 1'b1; tick();

    // Write transaction
    bus.cs_n = 1'b0; tick();
    addr_phase(1'b0);
    tick();
    chk("wr_no_load", bus.sr_load, 1'b0);
    for (int i = 0; i < D; i++) pulse(i == D - 1 ? 0 : 2);
    chk("wr_dm_we", bus.dm_we, 1'b1);
    tick();
    chk("wr_dm_we_1cyc", bus.dm_we, 1'b0);
    pulse(1);
    chk("wr_done_no_shift", last_shift, 1'b0);
    bus.cs_n = 1'b1; tick();
    chk("dm_cnt_write", dm_cnt == 1, 1'b1);

    // Reset after 3 data pulses of a write
    bus.cs_n = 1'b0; tick();
    addr_phase(1'b0);
    tick();
    for (int i = 0; i < 3; i++) pulse(1);
    reset = 1'b1; tick(); reset = 1'b0;
    outs_zero("rst_mid");
    bus.cs_n = 1'b1;
    for (int i = 0; i < 5; i++) pulse(1);
    chk("dm_cnt_rst", dm_cnt == 1, 1'b1);

    // Abort after 5 address pulses, then a fresh address needs 8 pulses
    bus.cs_n = 1'b0; tick();
    for (int i = 0; i < 5; i++) pulse(1);
    bus.cs_n = 1'b1; tick();
    outs_zero("abort");
    bus.cs_n = 1'b0; tick();
    addr_phase(1'b1);
    bus.cs_n = 1'b1; tick();
    chk("abort_no_load", bus.sr_load, 1'b0);
    tick();

    // Pulse coincident with cs_n falling is not counted
    bus.cs_n = 1'b0;
    bus.sclk_posedge = 1'b1;
    #1 chk("cs_fall_no_shift", bus.sr_shift_en, 1'b0);
    tick();
    bus.sclk_posedge = 1'b0;
    addr_phase(1'b0);
    tick();

    // cs_n rises during the dm_we cycle: write still commits
    for (int i = 0; i < D; i++) pulse(i == D - 1 ? 0 : 1);
    bus.cs_n = 1'b1;
    #1 chk("sim_dm_we", bus.dm_we, 1'b1);
    tick();
    outs_zero("sim_after");
    chk("dm_cnt_final", dm_cnt == 2, 1'b1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule
